// File: rtl/id_ex_hazard_unit_if.sv
// Hazard-unit bundle: decode sources, ID/EX and EX/MEM producer info,
// branch redirect, and the pipeline enable/flush/bubble controls.
interface id_ex_hazard_unit_if;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_halt;
  logic        idex_RegWrite;
  logic        idex_MemToReg;
  logic [2:0]  idex_writeReg;
  logic        exmem_RegWrite;
  logic [2:0]  exmem_writeReg;
  logic        branch_taken_ex;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        halt_done;
  logic [15:0] bubble_count;

  // Pipeline side: supplies stage information, consumes the controls.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
    output idex_RegWrite, idex_MemToReg, idex_writeReg,
    output exmem_RegWrite, exmem_writeReg, branch_taken_ex,
    input  pc_en, ifid_en, idex_en, idex_bubble, ifid_flush,
    input  halt_done, bubble_count
  );

  // Hazard unit side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
    input  idex_RegWrite, idex_MemToReg, idex_writeReg,
    input  exmem_RegWrite, exmem_writeReg, branch_taken_ex,
    output pc_en, ifid_en, idex_en, idex_bubble, ifid_flush,
    output halt_done, bubble_count
  );
endinterface

// File: rtl/id_ex_hazard_unit.sv
// ID/EX hazard controller: RAW stalls against ID/EX and EX/MEM producers,
// branch flush with a follow-up kill cycle, and HALT drain to a halted state.
// Pipeline controls are combinational; halt_done and bubble_count are registered.
module id_ex_hazard_unit (
  input  logic               clk,
  input  logic               rst,
  id_ex_hazard_unit_if.slave hz
);

  typedef enum logic [2:0] {RUN, STALL, FLUSH, DRAIN, HALTED} state_e;

  state_e      state_q, state_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;
  logic        halt_done_q;
  logic [15:0] bubble_count_q, bubble_count_d;

  logic        rs_hit, rt_hit, raw_hit;
  logic        pc_en, ifid_en, idex_en, idex_bubble, ifid_flush;

  // Load-use is not distinguished: any in-flight write to a source stalls.
  logic        unused_memtoreg;
  assign unused_memtoreg = hz.idex_MemToReg;

  function automatic logic src_match(input logic [2:0] r,
                                     input logic       idex_we,
                                     input logic [2:0] idex_wr,
                                     input logic       exmem_we,
                                     input logic [2:0] exmem_wr);
    return (idex_we && (idex_wr == r)) || (exmem_we && (exmem_wr == r));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  assign rs_hit  = hz.id_uses_rs && src_match(hz.id_rs, hz.idex_RegWrite, hz.idex_writeReg,
                                              hz.exmem_RegWrite, hz.exmem_writeReg);
  assign rt_hit  = hz.id_uses_rt && src_match(hz.id_rt, hz.idex_RegWrite, hz.idex_writeReg,
                                              hz.exmem_RegWrite, hz.exmem_writeReg);
  assign raw_hit = rs_hit || rt_hit;

  // Next state and pipeline controls; priority is branch > RAW > HALT.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    case (state_q)
      RUN, STALL: begin
        if (hz.branch_taken_ex) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = FLUSH;
        end else if (raw_hit) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          state_d     = STALL;
        end else if (hz.id_halt) begin
          // HALT itself moves into ID/EX; fetch freezes behind it.
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          drain_cnt_d = 2'd3;
          state_d     = DRAIN;
        end else begin
          state_d     = RUN;
        end
      end
      FLUSH: begin
        // Kill the slot fetched alongside the redirect; a new redirect flushes again.
        idex_bubble = 1'b1;
        if (hz.branch_taken_ex) begin
          ifid_flush = 1'b1;
          state_d    = FLUSH;
        end else begin
          state_d    = RUN;
        end
      end
      DRAIN: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        drain_cnt_d = drain_cnt_q - 2'd1;
        if (drain_cnt_q <= 2'd1) state_d = HALTED;
      end
      HALTED: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
      end
      default: state_d = RUN;
    endcase
    // While reset is asserted the pipeline runs freely with no bubbles.
    if (!rst) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
    end
  end

  assign bubble_count_d = sat_inc(bubble_count_q, idex_bubble);

  // State, drain counter, halt flag and saturating bubble counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      drain_cnt_q    <= 2'd0;
      halt_done_q    <= 1'b0;
      bubble_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      halt_done_q    <= (state_d == HALTED);
      bubble_count_q <= bubble_count_d;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.idex_en      = idex_en;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.halt_done    = halt_done_q;
  assign hz.bubble_count = bubble_count_q;

endmodule

// File: doc/id_ex_hazard_unit.md
ID_EX_HAZARD_UNIT -- requirements
Module: id_ex_hazard_unit

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-low (rst=0 at a rising clk edge resets).
REQ-003 SHALL have ports: id_rs, id_rt  in  3 each  source register fields of instruction in decode.
REQ-004 SHALL have ports: id_uses_rs, id_uses_rt  in  1 each  decode instruction reads that source.
REQ-005 SHALL have port: id_halt  in  1  decode instruction is HALT.
REQ-006 SHALL have ports: idex_RegWrite, idex_MemToReg  in  1 each; idex_writeReg  in  3  (consumer side of ID/EX latch).
REQ-007 SHALL have ports: exmem_RegWrite  in  1; exmem_writeReg  in  3.
REQ-008 SHALL have port: branch_taken_ex  in  1  EX stage redirecting PC this cycle.
REQ-009 SHALL have outputs, 1 bit each: pc_en, ifid_en, idex_en, idex_bubble (zero all ID/EX control inputs), ifid_flush, halt_done.
REQ-010 SHALL have output: bubble_count  out  16  saturating count of inserted bubbles.

Function
REQ-011 SHALL implement FSM states RUN, STALL, FLUSH, DRAIN, HALTED; reset state RUN.
REQ-012 RAW hit SHALL be: (id_uses_rs and rs matches) or (id_uses_rt and rt matches), where match = (idex_RegWrite and idex_writeReg==reg) or (exmem_RegWrite and exmem_writeReg==reg).
REQ-013 RUN, no event: pc_en=ifid_en=idex_en=1, idex_bubble=0, ifid_flush=0.
REQ-014 RUN with RAW hit: same cycle pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1; next state STALL.
REQ-015 STALL: re-evaluate RAW each cycle; while hit, hold outputs of REQ-014; when clear, outputs as REQ-013 and next state RUN.
REQ-016 branch_taken_ex in RUN or STALL SHALL win over RAW: same cycle pc_en=1, ifid_flush=1, idex_bubble=1, idex_en=1; next state FLUSH.
REQ-017 FLUSH: exactly one cycle with ifid_flush=0, idex_bubble=1 (kill refetched slot), pc_en=1; next state RUN; branch_taken_ex in FLUSH re-enters FLUSH for one more cycle.
REQ-018 id_halt in RUN with no RAW hit and no branch: pc_en=0, ifid_en=0, idex_bubble=0 for that cycle (HALT enters ID/EX); next state DRAIN, drain counter loaded with 3.
REQ-019 id_halt with RAW hit SHALL stall first per REQ-014; halt accepted only once clear; branch_taken_ex overrides halt.
REQ-020 DRAIN: pc_en=ifid_en=0, idex_bubble=1, counter decrements each cycle; at counter 0 next state HALTED; branch_taken_ex ignored in DRAIN.
REQ-021 HALTED: pc_en=ifid_en=idex_en=0, halt_done=1; exits only by reset.
REQ-022 bubble_count SHALL increment by 1 on every cycle idex_bubble=1 and rst=1, saturating at 16'hFFFF.
REQ-023 Outputs SHALL be combinational from state and inputs except halt_done and bubble_count, which SHALL be registered.

Reset
REQ-024 On rst=0 at clk edge: state RUN, drain counter 0, bubble_count 0, halt_done 0; asserting rst mid-STALL/FLUSH/DRAIN/HALTED returns to RUN next cycle.
REQ-025 During the reset cycle outputs SHALL be pc_en=1, ifid_en=1, idex_en=1, idex_bubble=0, ifid_flush=0.

Verification
REQ-026 idex_RegWrite=1, idex_writeReg=3, id_rs=3, id_uses_rs=1 one cycle -> pc_en=0, idex_bubble=1 that cycle; next cycle (hazard moved to exmem_writeReg=3) still stall; then RUN, bubble_count=2.
REQ-027 RAW hit and branch_taken_ex same cycle -> ifid_flush=1, pc_en=1, next cycle idex_bubble=1, ifid_flush=0, then RUN; bubble_count=2.
REQ-028 id_halt=1 with no hazards -> one cycle pc_en=0, idex_bubble=0, three DRAIN cycles idex_bubble=1, then halt_done=1 held indefinitely.
REQ-029 Preload bubble_count near saturation by 65540 stall cycles -> bubble_count stays 16'hFFFF, no wrap.
REQ-030 rst=0 asserted in DRAIN and in HALTED -> next cycle state RUN, halt_done=0, bubble_count=0, pc_en=1.
REQ-031 id_uses_rt=0 with id_rt matching idex_writeReg -> no stall, pc_en=1.
